key_assembler: RTL
==================

# key_assembler

Sequencer that builds a printable key, one character at a time, around the existing 8-bit modulus stage. It takes a random byte from the upstream RNG through a valid/ready handshake and pulses the modulus stage's `ready_in`. It then waits for that stage's `valid_out` and maps the remainder to ASCII (0-9, A-Z, a-z). Each character is written into the downstream key buffer by index, and completion of the whole key is signalled once.

## Interface
- `KEY_LEN`, default 16: characters per key, legal 1..255.
- `MOD_VALUE`, default 62: divisor driven to the modulus stage, legal 1..255.
- `clk_in` in 1: system clock, rising edge.
- `rst_n_in` in 1: reset, asynchronous and active-low.
- `start_in` in 1: begin a new key; sampled only in IDLE.
- `rand_valid_in` in 1: RNG byte available.
- `rand_data_in` in 8: RNG byte.
- `rand_ready_out` out 1: byte accepted when `rand_valid_in && rand_ready_out`.
- `mod_ready_out` out 1: single-cycle start pulse to the modulus `ready_in`.
- `mod_value_out` out 8: dividend; held stable from ISSUE until the result is captured.
- `mod_modulus_out` out 8: constant `MOD_VALUE`.
- `mod_busy_in` in 1: modulus `busy_out`.
- `mod_valid_in` in 1: modulus `valid_out`.
- `mod_result_in` in 8: modulus `value_out`.
- `char_out` out 8: ASCII character.
- `char_idx_out` out `$clog2(KEY_LEN+1)`: write index, 0..KEY_LEN-1.
- `char_we_out` out 1: one-cycle write strobe.
- `key_done_out` out 1: one-cycle pulse after the last write.
- `busy_out` out 1: high in every state except IDLE.

## Operation
States and transitions:
- IDLE: on `start_in`, clear the index and go to FETCH.
- FETCH: `rand_ready_out`=1. On handshake, register the byte into `mod_value_out` and go to ISSUE.
- ISSUE: `mod_ready_out`=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `mod_busy_in`=1, then go to WAIT_VALID.
- WAIT_VALID: on `mod_valid_in`, register `char_map(mod_result_in)` and go to WRITE.
- WRITE: `char_we_out`=1 and the index increments. If the new index equals KEY_LEN, go to DONE; else go to FETCH.
- DONE: `key_done_out`=1, index returns to 0, go to IDLE.

Character mapping:
- r 0..9 maps to 0x30+r.
- r 10..35 maps to 0x41+r-10.
- r 36..61 maps to 0x61+r-36.
- r ≥ 62 maps to 0x3F ('?').

Ignored events:
- `start_in` outside IDLE.
- `mod_valid_in` outside WAIT_VALID.
- `rand_valid_in` outside FETCH.

Reset and corner cases:
- Reset values: all outputs 0, state IDLE, index 0, `mod_modulus_out`=`MOD_VALUE`.
- Reset mid-key: returns to IDLE immediately; the partial key is abandoned and no `key_done_out` is produced.
- KEY_LEN=1: WRITE goes straight to DONE.

## Timing
- Byte handshake in cycle t.
- ISSUE in t+1.
- Modulus busy is seen in t+2.
- WAIT_VALID lasts for the modulus compute time.
- WRITE occurs the cycle after `mod_valid_in`; DONE follows the last WRITE by one cycle.
- Per-character overhead excluding modulus latency: 4 cycles (FETCH, ISSUE, WAIT_BUSY, WRITE).
- Latency is not hard-coded; all progress is handshake-driven.
- `mod_value_out` must stay constant through WAIT_VALID, because the modulus stage samples its dividend at completion, not at start.

## Configuration
- `KEY_ASSEMBLER_REJECT_EN` defined: FETCH accepts, and silently discards, bytes ≥ LIMIT, where LIMIT = 256 − (256 % MOD_VALUE) (248 for 62). It stays in FETCH, which removes modulo bias.
- Not defined: every byte is used.

## Structure
- `keychain_pkg` holds:
  - the state enum typedef;
  - `CHARSET_SIZE`=62;
  - ASCII bases 0x30/0x41/0x61/0x3F;
  - a function computing the rejection limit.
- One sub-module, `char_map`: combinational 8-bit remainder → ASCII.
- The FSM, index counter and output registers live in `key_assembler`.

## Test plan
All scenarios run against a behavioural modulus model with a 17-cycle busy window.
- KEY_LEN=4, start, RNG bytes 0x41, 0x3D, 0x0A, 0x24 → writes `33@0`, `7A@1`, `41@2`, `61@3`, then one `key_done_out` pulse; `mod_ready_out` pulses exactly 4 times.
- RNG withholds `rand_valid_in` for 10 cycles in FETCH → no `mod_ready_out`, `busy_out` stays 1, and progress resumes on valid.
- `start_in` and a spurious `mod_valid_in` during WAIT_BUSY → ignored; index and state unchanged.
- Reset asserted during WAIT_VALID of character 2 → all outputs 0 the same cycle; a fresh start writes from index 0.
- With `KEY_ASSEMBLER_REJECT_EN`, bytes 0xF8 then 0x05 → 0xF8 consumed without an ISSUE, then `35@0`. Without the macro, 0xF8 → `30@0`.
- MOD_VALUE=100, byte 0x50 (80) → `char_out` 0x3F.

Source files
------------

// File: rtl/keychain_pkg.sv
// keychain_pkg: shared types and constants for the key assembler.
//   state_t        - sequencer state encoding (also exported on the debug port)
//   CHARSET_SIZE   - number of printable symbols (0-9, A-Z, a-z)
//   ASCII_*        - ASCII bases for each symbol group and the invalid marker
//   reject_limit() - smallest byte value that would bias a modulo reduction
package keychain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_BUSY  = 3'd3,
    ST_WAIT_VALID = 3'd4,
    ST_WRITE      = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  localparam logic [7:0] CHARSET_SIZE     = 8'd62;
  localparam logic [7:0] DIGIT_COUNT      = 8'd10;
  localparam logic [7:0] UPPER_END        = 8'd36;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;
  localparam logic [7:0] ASCII_INVALID    = 8'h3F;

  // Bytes at or above this value fall in the incomplete last "wrap" of the
  // modulus and would over-represent the low remainders. Nine bits because
  // a divisor of 256's factors yields 256 (nothing rejected).
  function automatic logic [8:0] reject_limit(input int unsigned modulus);
    return 9'(256 - (256 % modulus));
  endfunction

endpackage

// File: rtl/key_assembler_char_map.sv
// char_map: combinational remainder-to-ASCII mapping.
//   rem_in   [7:0] - remainder from the modulus stage
//   char_out [7:0] - 0..9 -> '0'..'9', 10..35 -> 'A'..'Z',
//                    36..61 -> 'a'..'z', anything else -> '?'
module char_map
  import keychain_pkg::*;
(
  input  logic [7:0] rem_in,
  output logic [7:0] char_out
);

  always_comb begin
    char_out = ASCII_INVALID;
    if (rem_in < DIGIT_COUNT) begin
      char_out = ASCII_DIGIT_BASE + rem_in;
    end else if (rem_in < UPPER_END) begin
      char_out = ASCII_UPPER_BASE + (rem_in - DIGIT_COUNT);
    end else if (rem_in < CHARSET_SIZE) begin
      char_out = ASCII_LOWER_BASE + (rem_in - UPPER_END);
    end
  end

endmodule

// File: rtl/key_assembler.sv
// key_assembler: builds a printable key one character at a time around an
// external 8-bit modulus stage.
//   clk_in, rst_n_in          - clock (rising edge), async active-low reset
//   start_in                  - begin a new key (only honoured in IDLE)
//   rand_valid_in/data_in     - RNG byte stream; rand_ready_out accepts it
//   mod_ready_out             - one-cycle start pulse to the modulus stage
//   mod_value_out             - dividend, held from ISSUE until capture
//   mod_modulus_out           - constant divisor MOD_VALUE
//   mod_busy_in/valid_in/result_in - modulus stage status and remainder
//   char_out/char_idx_out/char_we_out - indexed write into the key buffer
//   key_done_out              - one-cycle pulse after the last write
//   busy_out                  - high whenever not IDLE
//   state_dbg_out             - current sequencer state
// Build option: KEY_ASSEMBLER_REJECT_EN discards RNG bytes at or above the
// modulo-bias limit while in FETCH (they are accepted but never issued).
//
// Handshakes: a byte transfers on a rising edge where rand_valid_in and
// rand_ready_out are both high; the modulus stage is started by the single
// mod_ready_out pulse and reports completion with a one-cycle mod_valid_in.
module key_assembler
  import keychain_pkg::*;
#(
  parameter int KEY_LEN   = 16,
  parameter int MOD_VALUE = 62
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           start_in,
  input  logic                           rand_valid_in,
  input  logic [7:0]                     rand_data_in,
  output logic                           rand_ready_out,
  output logic                           mod_ready_out,
  output logic [7:0]                     mod_value_out,
  output logic [7:0]                     mod_modulus_out,
  input  logic                           mod_busy_in,
  input  logic                           mod_valid_in,
  input  logic [7:0]                     mod_result_in,
  output logic [7:0]                     char_out,
  output logic [$clog2(KEY_LEN+1)-1:0]   char_idx_out,
  output logic                           char_we_out,
  output logic                           key_done_out,
  output logic                           busy_out,
  output logic [2:0]                     state_dbg_out
);

  localparam int IDX_W = $clog2(KEY_LEN + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         mod_value_q;
  logic [7:0]         char_q;
  logic [7:0]         mapped_char;
  logic               byte_ok;
  logic               last_char;
  logic               load_byte, load_char, clr_idx, inc_idx;
  logic               rand_ready_c, mod_ready_c, char_we_c, key_done_c;

  char_map u_char_map (
    .rem_in   (mod_result_in),
    .char_out (mapped_char)
  );

`ifdef KEY_ASSEMBLER_REJECT_EN
  localparam logic [8:0] REJECT_LIMIT = reject_limit(MOD_VALUE);
  assign byte_ok = ({1'b0, rand_data_in} < REJECT_LIMIT);
`else
  assign byte_ok = 1'b1;
`endif

  assign last_char = (idx_q == IDX_W'(KEY_LEN - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rand_ready_c = 1'b0;
    mod_ready_c  = 1'b0;
    char_we_c    = 1'b0;
    key_done_c   = 1'b0;
    load_byte    = 1'b0;
    load_char    = 1'b0;
    clr_idx      = 1'b0;
    inc_idx      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          clr_idx = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rand_ready_c = 1'b1;
        // A rejected byte is still consumed; we simply wait for the next one.
        if (rand_valid_in && byte_ok) begin
          load_byte = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mod_ready_c = 1'b1;
        state_d     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (mod_busy_in) begin
          state_d = ST_WAIT_VALID;
        end
      end
      ST_WAIT_VALID: begin
        if (mod_valid_in) begin
          load_char = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        char_we_c = 1'b1;
        inc_idx   = 1'b1;
        state_d   = last_char ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        key_done_c = 1'b1;
        clr_idx    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // mod_value_q only changes in FETCH, so it stays stable while the modulus
  // stage samples it at the end of its compute window.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx_q       <= '0;
      mod_value_q <= '0;
      char_q      <= '0;
    end else begin
      if (clr_idx) begin
        idx_q <= '0;
      end else if (inc_idx) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (load_byte) begin
        mod_value_q <= rand_data_in;
      end
      if (load_char) begin
        char_q <= mapped_char;
      end
    end
  end

  assign rand_ready_out  = rand_ready_c;
  assign mod_ready_out   = mod_ready_c;
  assign mod_value_out   = mod_value_q;
  assign mod_modulus_out = 8'(MOD_VALUE);
  assign char_out        = char_q;
  assign char_idx_out    = idx_q;
  assign char_we_out     = char_we_c;
  assign key_done_out    = key_done_c;
  assign busy_out        = (state_q != ST_IDLE);
  assign state_dbg_out   = state_q;

endmodule
